// File: rtl/rs_alu.sv
// ALU reservation station: holds dispatched ALU ops until both operands are
// resolved via the ALU/LSB broadcast buses, then issues one ready op per cycle.
module rs_alu #(
    parameter int unsigned RS_SIZE = 8,
    parameter int unsigned ROB_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdy,
    input  logic             clear,

    input  logic             in_en,
    input  logic [ROB_W-1:0] in_rob_id,
    input  logic [5:0]       in_opcode,
    input  logic [31:0]      in_vj,
    input  logic [31:0]      in_vk,
    input  logic             in_qj_valid,
    input  logic             in_qk_valid,
    input  logic [ROB_W-1:0] in_qj,
    input  logic [ROB_W-1:0] in_qk,
    input  logic [31:0]      in_imm,
    input  logic [31:0]      in_pc,

    input  logic             alu_cdb_valid,
    input  logic [ROB_W-1:0] alu_cdb_rob_id,
    input  logic [31:0]      alu_cdb_val,
    input  logic             lsb_cdb_valid,
    input  logic [ROB_W-1:0] lsb_cdb_rob_id,
    input  logic [31:0]      lsb_cdb_val,

    output logic             full,
    output logic             work_en,
    output logic [ROB_W-1:0] rob_id,
    output logic [5:0]       opcode,
    output logic [31:0]      rs1,
    output logic [31:0]      rs2,
    output logic [31:0]      imm,
    output logic [31:0]      pc
);

    localparam int unsigned IdxW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
    localparam int unsigned OccW = $clog2(RS_SIZE + 1);

    // Entry storage
    logic [RS_SIZE-1:0] busy_q, busy_d;
    logic [RS_SIZE-1:0] qjv_q, qjv_d;
    logic [RS_SIZE-1:0] qkv_q, qkv_d;
    logic [ROB_W-1:0]   tag_q [RS_SIZE];
    logic [ROB_W-1:0]   tag_d [RS_SIZE];
    logic [5:0]         op_q  [RS_SIZE];
    logic [5:0]         op_d  [RS_SIZE];
    logic [31:0]        vj_q  [RS_SIZE];
    logic [31:0]        vj_d  [RS_SIZE];
    logic [31:0]        vk_q  [RS_SIZE];
    logic [31:0]        vk_d  [RS_SIZE];
    logic [ROB_W-1:0]   qj_q  [RS_SIZE];
    logic [ROB_W-1:0]   qj_d  [RS_SIZE];
    logic [ROB_W-1:0]   qk_q  [RS_SIZE];
    logic [ROB_W-1:0]   qk_d  [RS_SIZE];
    logic [31:0]        imm_q [RS_SIZE];
    logic [31:0]        imm_d [RS_SIZE];
    logic [31:0]        pc_q  [RS_SIZE];
    logic [31:0]        pc_d  [RS_SIZE];

    logic [OccW-1:0]    occ_q, occ_d;

    // Issue port registers
    logic               work_en_q, work_en_d;
    logic [ROB_W-1:0]   rob_id_q, rob_id_d;
    logic [5:0]         opcode_q, opcode_d;
    logic [31:0]        rs1_q, rs1_d;
    logic [31:0]        rs2_q, rs2_d;
    logic [31:0]        imm_out_q, imm_out_d;
    logic [31:0]        pc_out_q, pc_out_d;

    logic               free_found, sel_found, disp_ok;
    logic [IdxW-1:0]    free_idx, sel_idx;

    function automatic logic bus_hit(input logic             bus_valid,
                                     input logic [ROB_W-1:0] bus_tag,
                                     input logic [ROB_W-1:0] tag);
        return bus_valid && (bus_tag == tag);
    endfunction

    assign full = (occ_q == OccW'(RS_SIZE));

    // Lowest free slot and lowest ready entry, both from registered state only.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_found = 1'b1;
                free_idx   = IdxW'(i);
            end
            if (busy_q[i] && !qjv_q[i] && !qkv_q[i]) begin
                sel_found = 1'b1;
                sel_idx   = IdxW'(i);
            end
        end
    end

    always_comb begin
        busy_d    = busy_q;
        qjv_d     = qjv_q;
        qkv_d     = qkv_q;
        tag_d     = tag_q;
        op_d      = op_q;
        vj_d      = vj_q;
        vk_d      = vk_q;
        qj_d      = qj_q;
        qk_d      = qk_q;
        imm_d     = imm_q;
        pc_d      = pc_q;
        occ_d     = occ_q;
        work_en_d = work_en_q;
        rob_id_d  = rob_id_q;
        opcode_d  = opcode_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        imm_out_d = imm_out_q;
        pc_out_d  = pc_out_q;
        disp_ok   = 1'b0;

        if (rdy) begin
            if (clear) begin
                busy_d    = '0;
                occ_d     = '0;
                work_en_d = 1'b0;
            end else begin
                // Wakeup; ALU bus takes priority if both buses carry the same tag.
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy_q[i] && qjv_q[i]) begin
                        if (bus_hit(alu_cdb_valid, alu_cdb_rob_id, qj_q[i])) begin
                            vj_d[i]  = alu_cdb_val;
                            qjv_d[i] = 1'b0;
                        end else if (bus_hit(lsb_cdb_valid, lsb_cdb_rob_id, qj_q[i])) begin
                            vj_d[i]  = lsb_cdb_val;
                            qjv_d[i] = 1'b0;
                        end
                    end
                    if (busy_q[i] && qkv_q[i]) begin
                        if (bus_hit(alu_cdb_valid, alu_cdb_rob_id, qk_q[i])) begin
                            vk_d[i]  = alu_cdb_val;
                            qkv_d[i] = 1'b0;
                        end else if (bus_hit(lsb_cdb_valid, lsb_cdb_rob_id, qk_q[i])) begin
                            vk_d[i]  = lsb_cdb_val;
                            qkv_d[i] = 1'b0;
                        end
                    end
                end

                work_en_d = sel_found;
                if (sel_found) begin
                    rob_id_d        = tag_q[sel_idx];
                    opcode_d        = op_q[sel_idx];
                    rs1_d           = vj_q[sel_idx];
                    rs2_d           = vk_q[sel_idx];
                    imm_out_d       = imm_q[sel_idx];
                    pc_out_d        = pc_q[sel_idx];
                    busy_d[sel_idx] = 1'b0;
                end

                // The free slot is never the issuing one, so a freed slot waits a cycle.
                if (in_en && !full && free_found) begin
                    disp_ok          = 1'b1;
                    busy_d[free_idx] = 1'b1;
                    tag_d[free_idx]  = in_rob_id;
                    op_d[free_idx]   = in_opcode;
                    imm_d[free_idx]  = in_imm;
                    pc_d[free_idx]   = in_pc;
                    qj_d[free_idx]   = in_qj;
                    qk_d[free_idx]   = in_qk;
                    vj_d[free_idx]   = in_vj;
                    qjv_d[free_idx]  = in_qj_valid;
                    vk_d[free_idx]   = in_vk;
                    qkv_d[free_idx]  = in_qk_valid;
                    if (in_qj_valid) begin
                        if (bus_hit(alu_cdb_valid, alu_cdb_rob_id, in_qj)) begin
                            vj_d[free_idx]  = alu_cdb_val;
                            qjv_d[free_idx] = 1'b0;
                        end else if (bus_hit(lsb_cdb_valid, lsb_cdb_rob_id, in_qj)) begin
                            vj_d[free_idx]  = lsb_cdb_val;
                            qjv_d[free_idx] = 1'b0;
                        end
                    end
                    if (in_qk_valid) begin
                        if (bus_hit(alu_cdb_valid, alu_cdb_rob_id, in_qk)) begin
                            vk_d[free_idx]  = alu_cdb_val;
                            qkv_d[free_idx] = 1'b0;
                        end else if (bus_hit(lsb_cdb_valid, lsb_cdb_rob_id, in_qk)) begin
                            vk_d[free_idx]  = lsb_cdb_val;
                            qkv_d[free_idx] = 1'b0;
                        end
                    end
                end

                occ_d = occ_q + OccW'(disp_ok) - OccW'(sel_found);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= '0;
            qjv_q     <= '0;
            qkv_q     <= '0;
            tag_q     <= '{default: '0};
            op_q      <= '{default: '0};
            vj_q      <= '{default: '0};
            vk_q      <= '{default: '0};
            qj_q      <= '{default: '0};
            qk_q      <= '{default: '0};
            imm_q     <= '{default: '0};
            pc_q      <= '{default: '0};
            occ_q     <= '0;
            work_en_q <= 1'b0;
            rob_id_q  <= '0;
            opcode_q  <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_out_q <= '0;
            pc_out_q  <= '0;
        end else begin
            busy_q    <= busy_d;
            qjv_q     <= qjv_d;
            qkv_q     <= qkv_d;
            tag_q     <= tag_d;
            op_q      <= op_d;
            vj_q      <= vj_d;
            vk_q      <= vk_d;
            qj_q      <= qj_d;
            qk_q      <= qk_d;
            imm_q     <= imm_d;
            pc_q      <= pc_d;
            occ_q     <= occ_d;
            work_en_q <= work_en_d;
            rob_id_q  <= rob_id_d;
            opcode_q  <= opcode_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            imm_out_q <= imm_out_d;
            pc_out_q  <= pc_out_d;
        end
    end

    assign work_en = work_en_q;
    assign rob_id  = rob_id_q;
    assign opcode  = opcode_q;
    assign rs1     = rs1_q;
    assign rs2     = rs2_q;
    assign imm     = imm_out_q;
    assign pc      = pc_out_q;

endmodule

// File: tb/tb_rs_alu.sv
// Self-checking bench for rs_alu: vector table plus hand-written corner sequences,
// with issued instructions checked against a scoreboard queue.
module tb_rs_alu;

    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic        clear;
    logic        in_en;
    logic [3:0]  in_rob_id;
    logic [5:0]  in_opcode;
    logic [31:0] in_vj, in_vk;
    logic        in_qj_valid, in_qk_valid;
    logic [3:0]  in_qj, in_qk;
    logic [31:0] in_imm, in_pc;
    logic        alu_cdb_valid;
    logic [3:0]  alu_cdb_rob_id;
    logic [31:0] alu_cdb_val;
    logic        lsb_cdb_valid;
    logic [3:0]  lsb_cdb_rob_id;
    logic [31:0] lsb_cdb_val;
    logic        full, work_en;
    logic [3:0]  rob_id;
    logic [5:0]  opcode;
    logic [31:0] rs1, rs2, imm, pc;

    rs_alu #(.RS_SIZE(8), .ROB_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rdy           (rdy),
        .clear         (clear),
        .in_en         (in_en),
        .in_rob_id     (in_rob_id),
        .in_opcode     (in_opcode),
        .in_vj         (in_vj),
        .in_vk         (in_vk),
        .in_qj_valid   (in_qj_valid),
        .in_qk_valid   (in_qk_valid),
        .in_qj         (in_qj),
        .in_qk         (in_qk),
        .in_imm        (in_imm),
        .in_pc         (in_pc),
        .alu_cdb_valid (alu_cdb_valid),
        .alu_cdb_rob_id(alu_cdb_rob_id),
        .alu_cdb_val   (alu_cdb_val),
        .lsb_cdb_valid (lsb_cdb_valid),
        .lsb_cdb_rob_id(lsb_cdb_rob_id),
        .lsb_cdb_val   (lsb_cdb_val),
        .full          (full),
        .work_en       (work_en),
        .rob_id        (rob_id),
        .opcode        (opcode),
        .rs1           (rs1),
        .rs2           (rs2),
        .imm           (imm),
        .pc            (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rob;
        logic [5:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
    } exp_t;

    // byp: 0 none, 1 = k operand pending on tag 6 and bypassed from LSB bus,
    // 2 = j operand pending on tag 12 and bypassed from ALU bus.
    typedef struct {
        logic [3:0]  tag;
        logic [5:0]  op;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [31:0] imm;
        logic [31:0] pc;
        int          byp;
        logic [31:0] bval;
        logic [31:0] exp_rs1;
        logic [31:0] exp_rs2;
    } vec_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock edge and compare any fresh issue against the scoreboard.
    task automatic tick();
        logic live;
        exp_t e;
        live = rdy && rst_n;
        @(posedge clk);
        #1;
        if (live && work_en) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_issue: got rob_id=%0d expected no issue", rob_id);
            end else begin
                e = exp_q.pop_front();
                check("sb_rob_id", 32'(rob_id), 32'(e.rob));
                check("sb_opcode", 32'(opcode), 32'(e.op));
                check("sb_rs1", rs1, e.rs1);
                check("sb_rs2", rs2, e.rs2);
                check("sb_imm", imm, e.imm);
                check("sb_pc", pc, e.pc);
            end
        end
    endtask

    task automatic idle();
        in_en         = 1'b0;
        clear         = 1'b0;
        alu_cdb_valid = 1'b0;
        lsb_cdb_valid = 1'b0;
    endtask

    task automatic set_disp(input logic [3:0] tag, input logic [5:0] op,
                            input logic [31:0] vj, input logic qjv, input logic [3:0] qj,
                            input logic [31:0] vk, input logic qkv, input logic [3:0] qk,
                            input logic [31:0] im, input logic [31:0] p);
        in_en       = 1'b1;
        in_rob_id   = tag;
        in_opcode   = op;
        in_vj       = vj;
        in_qj_valid = qjv;
        in_qj       = qj;
        in_vk       = vk;
        in_qk_valid = qkv;
        in_qk       = qk;
        in_imm      = im;
        in_pc       = p;
    endtask

    vec_t vec [6];

    initial begin
        vec[0] = '{4'd1, 6'h02, 32'h3, 32'h4, 32'h10, 32'h2000, 0, 32'h0, 32'h3, 32'h4};
        vec[1] = '{4'd3, 6'h05, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFC, 32'h2004, 0,
                   32'h0, 32'hFFFF_FFFF, 32'h8000_0000};
        vec[2] = '{4'd8, 6'h0A, 32'h1234_5678, 32'hDEAD_0000, 32'h0, 32'h2008, 1,
                   32'hABCD, 32'h1234_5678, 32'hABCD};
        vec[3] = '{4'd9, 6'h11, 32'hCAFE_0000, 32'h42, 32'h7, 32'h200C, 2,
                   32'h5555_AAAA, 32'h5555_AAAA, 32'h42};
        vec[4] = '{4'd15, 6'h3F, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 0, 32'h0,
                   32'h0, 32'h0};
        vec[5] = '{4'd0, 6'h00, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h1, 32'h0, 1, 32'hBEEF,
                   32'hA5A5_A5A5, 32'hBEEF};

        rst_n = 1'b0;
        rdy   = 1'b1;
        idle();
        set_disp(4'd0, 6'h0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 32'h0);
        in_en = 1'b0;
        alu_cdb_rob_id = 4'd0;
        alu_cdb_val    = 32'h0;
        lsb_cdb_rob_id = 4'd0;
        lsb_cdb_val    = 32'h0;

        // Reset values
        #12;
        check("rst_full", 32'(full), 0);
        check("rst_work_en", 32'(work_en), 0);
        check("rst_rob_id", 32'(rob_id), 0);
        check("rst_rs1", rs1, 0);
        check("rst_pc", pc, 0);
        rst_n = 1'b1;
        tick();

        // Ready ADD: two-edge latency, one-cycle pulse
        set_disp(4'd2, 6'h01, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 32'h100, 32'h1000);
        exp_q.push_back('{4'd2, 6'h01, 32'd5, 32'd7, 32'h100, 32'h1000});
        tick();
        idle();
        check("add_not_yet", 32'(work_en), 0);
        tick();
        check("add_work_en", 32'(work_en), 1);
        check("add_rob_id", 32'(rob_id), 2);
        check("add_rs1", rs1, 5);
        check("add_rs2", rs2, 7);
        tick();
        check("add_pulse_end", 32'(work_en), 0);

        // Vector table, one dispatch per cycle, some with same-cycle bypass
        for (int n = 0; n < 6; n++) begin
            set_disp(vec[n].tag, vec[n].op, vec[n].vj, vec[n].byp == 2, 4'd12,
                     vec[n].vk, vec[n].byp == 1, 4'd6, vec[n].imm, vec[n].pc);
            alu_cdb_valid  = (vec[n].byp == 2);
            alu_cdb_rob_id = 4'd12;
            alu_cdb_val    = vec[n].bval;
            lsb_cdb_valid  = (vec[n].byp == 1);
            lsb_cdb_rob_id = 4'd6;
            lsb_cdb_val    = vec[n].bval;
            exp_q.push_back('{vec[n].tag, vec[n].op, vec[n].exp_rs1, vec[n].exp_rs2,
                              vec[n].imm, vec[n].pc});
            tick();
            if (n > 0) check("vec_back_to_back", 32'(work_en), 1);
        end
        idle();
        tick();
        tick();
        check("vec_drained", 32'(exp_q.size()), 0);

        // Dependency wakeup via ALU bus
        set_disp(4'd4, 6'h03, 32'hDEAD, 1'b1, 4'd3, 32'd1, 1'b0, 4'd0, 32'h0, 32'h3000);
        exp_q.push_back('{4'd4, 6'h03, 32'h10, 32'd1, 32'h0, 32'h3000});
        tick();
        idle();
        tick();
        tick();
        check("dep_wait", 32'(work_en), 0);
        alu_cdb_valid  = 1'b1;
        alu_cdb_rob_id = 4'd3;
        alu_cdb_val    = 32'h10;
        tick();
        idle();
        check("dep_wake_edge", 32'(work_en), 0);
        tick();
        check("dep_issue", 32'(work_en), 1);
        check("dep_rs1", rs1, 32'h10);
        tick();

        // Fill all entries, reject a ninth, then drain in index order
        for (int i = 0; i < 8; i++) begin
            set_disp(4'(i), 6'h04, 32'h0, 1'b1, 4'd9, 32'(i * 3), 1'b0, 4'd0, 32'(i),
                     32'h4000 + 32'(i * 4));
            exp_q.push_back('{4'(i), 6'h04, 32'h99, 32'(i * 3), 32'(i),
                              32'h4000 + 32'(i * 4)});
            tick();
            if (i == 6) check("full_at_7", 32'(full), 0);
        end
        check("full_at_8", 32'(full), 1);
        set_disp(4'd13, 6'h07, 32'h1, 1'b0, 4'd0, 32'h2, 1'b0, 4'd0, 32'h0, 32'h0);
        tick();
        idle();
        check("full_hold", 32'(full), 1);
        tick();
        check("full_no_issue", 32'(work_en), 0);
        lsb_cdb_valid  = 1'b1;
        lsb_cdb_rob_id = 4'd9;
        lsb_cdb_val    = 32'h99;
        tick();
        idle();
        for (int k = 0; k < 8; k++) begin
            tick();
            check("drain_work_en", 32'(work_en), 1);
            check("drain_order", 32'(rob_id), 32'(k));
            if (k == 0) check("full_drop", 32'(full), 0);
        end
        tick();
        check("drain_end", 32'(work_en), 0);

        // rdy=0 freezes everything, including work_en and broadcasts
        set_disp(4'd1, 6'h08, 32'h11, 1'b0, 4'd0, 32'h22, 1'b0, 4'd0, 32'h0, 32'h5000);
        exp_q.push_back('{4'd1, 6'h08, 32'h11, 32'h22, 32'h0, 32'h5000});
        tick();
        idle();
        rdy = 1'b0;
        tick();
        tick();
        check("rdy_no_issue", 32'(work_en), 0);
        rdy = 1'b1;
        tick();
        check("rdy_issue", 32'(work_en), 1);
        rdy = 1'b0;
        tick();
        check("rdy_hold_work_en", 32'(work_en), 1);
        rdy = 1'b1;
        tick();
        check("rdy_pulse_end", 32'(work_en), 0);
        set_disp(4'd2, 6'h09, 32'h0, 1'b1, 4'd8, 32'h3, 1'b0, 4'd0, 32'h0, 32'h5004);
        tick();
        idle();
        rdy            = 1'b0;
        alu_cdb_valid  = 1'b1;
        alu_cdb_rob_id = 4'd8;
        alu_cdb_val    = 32'h77;
        tick();
        idle();
        rdy = 1'b1;
        tick();
        tick();
        check("rdy_bcast_ignored", 32'(work_en), 0);
        exp_q.push_back('{4'd2, 6'h09, 32'h88, 32'h3, 32'h0, 32'h5004});
        alu_cdb_valid  = 1'b1;
        alu_cdb_rob_id = 4'd8;
        alu_cdb_val    = 32'h88;
        tick();
        idle();
        tick();
        check("rdy_late_issue", 32'(work_en), 1);
        tick();

        // Clear with two entries just woken
        for (int i = 0; i < 5; i++) begin
            set_disp(4'(i), 6'h0C, 32'h0, 1'b1, (i < 3) ? 4'd9 : 4'd10, 32'h0, 1'b0, 4'd0,
                     32'h0, 32'h0);
            tick();
        end
        idle();
        alu_cdb_valid  = 1'b1;
        alu_cdb_rob_id = 4'd10;
        alu_cdb_val    = 32'h1;
        tick();
        idle();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_work_en", 32'(work_en), 0);
        check("clear_full", 32'(full), 0);
        tick();
        lsb_cdb_valid  = 1'b1;
        lsb_cdb_rob_id = 4'd9;
        lsb_cdb_val    = 32'h2;
        tick();
        idle();
        tick();
        check("clear_no_issue", 32'(work_en), 0);
        set_disp(4'd7, 6'h0D, 32'h70, 1'b0, 4'd0, 32'h71, 1'b0, 4'd0, 32'h0, 32'h6000);
        exp_q.push_back('{4'd7, 6'h0D, 32'h70, 32'h71, 32'h0, 32'h6000});
        tick();
        idle();
        check("clear_slot0", 32'(dut.busy_q), 32'h1);
        tick();
        tick();

        // Asynchronous reset mid-stream with three entries busy and an issue in flight
        for (int i = 0; i < 3; i++) begin
            set_disp(4'(i), 6'h0E, 32'h0, 1'b1, 4'd9, 32'h0, 1'b0, 4'd0, 32'h0, 32'h0);
            tick();
        end
        set_disp(4'd5, 6'h0F, 32'h55, 1'b0, 4'd0, 32'h66, 1'b0, 4'd0, 32'h0, 32'h7000);
        exp_q.push_back('{4'd5, 6'h0F, 32'h55, 32'h66, 32'h0, 32'h7000});
        tick();
        idle();
        tick();
        check("pre_rst_issue", 32'(work_en), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_work_en", 32'(work_en), 0);
        check("async_rst_full", 32'(full), 0);
        check("async_rst_rob_id", 32'(rob_id), 0);
        check("async_rst_rs1", rs1, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        lsb_cdb_valid  = 1'b1;
        lsb_cdb_rob_id = 4'd9;
        lsb_cdb_val    = 32'h3;
        tick();
        idle();
        tick();
        tick();
        check("post_rst_no_issue", 32'(work_en), 0);
        check("post_rst_full", 32'(full), 0);

        check("sb_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop if something wedges the sequence.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected summary");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rs_alu.md
# rs_alu

Reservation station in front of the ALU in the out-of-order core. It buffers dispatched ALU-class instructions and holds each operand until its producing ROB tag is broadcast on the ALU or LSB result bus. It then issues one ready instruction per cycle to the ALU as a single-cycle `work_en` pulse, carrying `rob_id`, `opcode`, `rs1`, `rs2`, `imm` and `pc`.

## Interface
- RS_SIZE, 8, number of entries (power of 2)
- ROB_W, 4, ROB tag width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rdy  in  1  global ready; when 0, every register holds its value
- clear  in  1  flush (branch mispredict); synchronous, gated by rdy
- in_en  in  1  dispatch valid
- in_rob_id  in  ROB_W  destination tag
- in_opcode  in  6  ALU opcode (OP_* encoding)
- in_vj, in_vk  in  32  operand values, meaningful when not pending
- in_qj_valid, in_qk_valid  in  1  operand pending
- in_qj, in_qk  in  ROB_W  producer tags
- in_imm, in_pc  in  32  immediate, instruction PC
- alu_cdb_valid  in  1  ALU broadcast (ALU `is_ok`)
- alu_cdb_rob_id  in  ROB_W  broadcast tag
- alu_cdb_val  in  32  broadcast value
- lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_val  in  1/ROB_W/32  LSB broadcast
- full  out  1  all entries busy (combinational from registers)
- work_en  out  1  issue pulse to ALU
- rob_id  out  ROB_W  issued tag
- opcode  out  6  issued opcode
- rs1, rs2, imm, pc  out  32  issued operands

## Operation
- Each entry holds: busy, tag, opcode, vj, qj_valid, qj, vk, qk_valid, qk, imm, pc.
- Dispatch (in_en=1, full=0): write the lowest-index entry with busy=0. Free-slot selection uses pre-edge busy bits. A slot freed by an issue in the same cycle is not reused until the next cycle.
- in_en=1 while full=1 is a protocol violation. The instruction is dropped and no state changes.
- Dispatch bypass: if in_qj_valid=1 and a valid broadcast tag equals in_qj in the same cycle, the entry stores that broadcast value with qj_valid=0. The k operand behaves the same way.
- Wakeup: for every busy entry with qj_valid=1 and qj matching a valid broadcast tag, vj ← value and qj_valid ← 0. The k operand behaves the same way. Both buses are checked in parallel. Their tags never coincide; if they do, the ALU bus wins.
- Ready means busy=1, qj_valid=0 and qk_valid=0, evaluated on registered state only. A wakeup at edge t makes the entry ready for selection at edge t+1.
- Select: the lowest-index ready entry. Only that entry is issued.
- Issue: at the edge, work_en ← 1, the outputs load from the entry (rs1=vj, rs2=vk), and the entry's busy ← 0.
- With no ready entry, work_en ← 0. The other outputs hold their last value.
- Clear overrides dispatch, wakeup and issue: all busy ← 0 and work_en ← 0. A dispatch arriving in the same cycle is discarded.
- While rdy=0, nothing is dispatched, woken or issued, and work_en holds. Broadcasts in such cycles are not observed.

## Timing
- Reset (rst_n=0, asynchronous): all busy=0, full=0, work_en=0, and rob_id/opcode/rs1/rs2/imm/pc=0.
- Reset asserted mid-operation takes effect immediately, without waiting for a clock edge. On release, the first edge behaves as idle.
- Ready dispatch sampled at edge t: work_en=1 after edge t+1, so latency is 2 edges from in_en to the issue pulse.
- Dependent operand: broadcast sampled at edge t, then work_en after edge t+1, if the entry was selected.
- At most one issue per cycle. work_en is high for exactly one cycle per issued instruction. Back-to-back issues give consecutive high cycles.
- full rises the cycle after the RS_SIZE-th dispatch edge. It falls the cycle after the edge that issues an entry or clears.
- Occupancy arithmetic is RS_SIZE+1 values wide (0..RS_SIZE). No wrap-around.

## Test plan
- Reset: hold rst_n=0 mid-stream with 3 entries busy, then release → full=0 and work_en=0 immediately; no issue afterwards.
- Ready ADD: dispatch tag 2, vj=5, vk=7, both not pending, at edge t → after edge t+1: work_en=1, rob_id=2, rs1=5, rs2=7; after edge t+2: work_en=0.
- Dependency: dispatch tag 4 with qj=3 pending and vk=1 → no issue. ALU broadcast tag 3, value 0x10, at edge t → after edge t+1: work_en=1, rs1=0x10, rs2=1.
- Bypass: dispatch with qk=6 pending in the same cycle as an LSB broadcast of tag 6, value 0xABCD → issued after the next edge with rs2=0xABCD.
- Full and drain: dispatch 8 entries, all waiting on tag 9 → full=1, and a 9th in_en is ignored. Broadcast tag 9 → 8 consecutive work_en cycles in index order; full drops after the first issue.
- Clear: 5 entries busy with 2 ready, assert clear → no work_en in the following cycles, full=0, and a new dispatch goes to entry 0.
